// File: rtl/mem_if_types.sv
// Shared types for the data-memory port: responder state, latched request, latency bound.
package mem_if_types;

  localparam int DMEM_MAX_LATENCY = 15;
  localparam int DMEM_INDEX_W     = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  typedef struct packed {
    logic [DMEM_INDEX_W-1:0] index;
    logic                    read;
    logic                    write;
    logic [3:0]              be;
    logic [31:0]             wdata;
  } dmem_req_t;

  // True when the word index reaches past an array of 2**aw words.
  function automatic logic index_out_of_range(input logic [DMEM_INDEX_W-1:0] index,
                                              input int unsigned aw);
    return (index >> aw) != '0;
  endfunction

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge: each enabled lane takes the new byte, the rest keep the old word.
module be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  byte_en,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the dmem port: accepts one request, waits LATENCY cycles,
// then returns a single-cycle response with read data or an error flag.
//
//   state | meaning
//   IDLE  | waiting; a read or write strobe is latched and accepted
//   BUSY  | counting down the latency on the latched copy, inputs ignored
//   RESP  | dmem_resp high for this one cycle, back to IDLE next
module dmem_responder
  import mem_if_types::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err
);

  localparam int         DEPTH    = 1 << ADDR_WORDS_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_resp_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  dmem_req_t        req_q, req_d, req_in, req_eff;

  logic                       enter_resp;
  logic                       req_err;
  logic                       do_write;
  logic [ADDR_WORDS_LOG2-1:0] mem_idx;
  logic [31:0]                mem_word;
  logic [31:0]                merged_word;
  logic [31:0]                mem [DEPTH];

  // The initiator word-aligns, so the byte offset carries no information.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^dmem_address[1:0];

  always_comb begin
    req_in.index = dmem_address[31:2];
    req_in.read  = dmem_read;
    req_in.write = dmem_write;
    req_in.be    = mem_byte_enable;
    req_in.wdata = dmem_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (dmem_read || dmem_write) begin
          req_d   = req_in;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the accept edge, so the live request is used.
  always_comb begin
    req_eff     = (state_q == IDLE) ? req_in : req_q;
    enter_resp  = (state_d == RESP) && (state_q != RESP);
    req_err     = (req_eff.read && req_eff.write) ||
                  index_out_of_range(req_eff.index, ADDR_WORDS_LOG2);
    do_write    = enter_resp && req_eff.write && !req_err;
    mem_idx     = req_eff.index[ADDR_WORDS_LOG2-1:0];
    mem_word    = mem[mem_idx];
  end

  be_merge u_be_merge (
    .old_word    (mem_word),
    .new_word    (req_eff.wdata),
    .byte_en     (req_eff.be),
    .merged_word (merged_word)
  );

  // The array sits in the reset block only so reset can block a commit; it is never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      dmem_resp  <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dmem_resp  <= enter_resp;
      dmem_err   <= enter_resp && req_err;
      dmem_rdata <= (enter_resp && req_eff.read && !req_err) ? mem_word : '0;
      if (do_write) mem[mem_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at LATENCY 2, 1 and 15: vector table through a scoreboard,
// plus hand-written held-request and reset-abort sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          sel = 0;
  logic [31:0] bus_addr = '0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [3:0]  bus_be = '0;
  logic [31:0] bus_wdata = '0;

  logic [31:0] rdata0, rdata1, rdata2, rdata_s;
  logic        resp0, resp1, resp2, resp_s;
  logic        err0, err1, err2, err_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  vec_t vq[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WORDS_LOG2(10), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .dmem_address(bus_addr),
    .dmem_read(bus_read && sel == 0), .dmem_write(bus_write && sel == 0),
    .mem_byte_enable(bus_be), .dmem_wdata(bus_wdata),
    .dmem_rdata(rdata0), .dmem_resp(resp0), .dmem_err(err0));

  dmem_responder #(.ADDR_WORDS_LOG2(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .dmem_address(bus_addr),
    .dmem_read(bus_read && sel == 1), .dmem_write(bus_write && sel == 1),
    .mem_byte_enable(bus_be), .dmem_wdata(bus_wdata),
    .dmem_rdata(rdata1), .dmem_resp(resp1), .dmem_err(err1));

  dmem_responder #(.ADDR_WORDS_LOG2(10), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .dmem_address(bus_addr),
    .dmem_read(bus_read && sel == 2), .dmem_write(bus_write && sel == 2),
    .mem_byte_enable(bus_be), .dmem_wdata(bus_wdata),
    .dmem_rdata(rdata2), .dmem_resp(resp2), .dmem_err(err2));

  always_comb begin
    rdata_s = rdata0;
    resp_s  = resp0;
    err_s   = err0;
    if (sel == 1) begin
      rdata_s = rdata1; resp_s = resp1; err_s = err1;
    end else if (sel == 2) begin
      rdata_s = rdata2; resp_s = resp2; err_s = err2;
    end
  end

  function automatic int lat_of(input int s);
    return (s == 1) ? 1 : (s == 2) ? 15 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " resp"},  {31'd0, resp_s}, 32'd0);
    chk({name, " err"},   {31'd0, err_s},  32'd0);
    chk({name, " rdata"}, rdata_s,         32'd0);
  endtask

  // Called just after a rising edge; drives the request and holds it until the response.
  task automatic do_req(input vec_t v, input int idx);
    exp_t e;
    int   n;
    bit   seen;
    string tag;
    tag = $sformatf("vec%0d", idx);
    e.err = v.err;
    e.rdata = v.rdata;
    e.lat = lat_of(v.sel);
    exp_q.push_back(e);
    sel = v.sel;
    bus_addr = v.addr;
    bus_read = v.rd;
    bus_write = v.wr;
    bus_be = v.be;
    bus_wdata = v.wdata;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (resp_s) seen = 1;
    end
    bus_read = 1'b0;
    bus_write = 1'b0;
    e = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no resp within %0d cycles, expected after %0d", tag, n, e.lat);
    end else begin
      chk({tag, " latency"}, 32'(n), 32'(e.lat));
      chk({tag, " err"}, {31'd0, err_s}, {31'd0, e.err});
      chk({tag, " rdata"}, rdata_s, e.rdata);
    end
    @(posedge clk); #1;
    chk({tag, " resp single cycle"}, {31'd0, resp_s}, 32'd0);
  endtask

  function automatic vec_t mk(input int s, input logic [31:0] a, input logic rd, input logic wr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic er, input logic [31:0] rdv);
    vec_t v;
    v.sel = s; v.addr = a; v.rd = rd; v.wr = wr; v.be = be; v.wdata = wd;
    v.err = er; v.rdata = rdv;
    return v;
  endfunction

  initial begin
    logic [9:0] pattern;

    //            sel addr          rd wr be     wdata         err rdata
    vq.push_back(mk(0, 32'h0000_0010, 0, 1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0010, 1, 0, 4'h0, 32'h0,         0, 32'hDEAD_BEEF));
    vq.push_back(mk(0, 32'h0000_0020, 0, 1, 4'hF, 32'h1122_3344, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0020, 0, 1, 4'h4, 32'h00AB_0000, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0020, 1, 0, 4'hF, 32'h0,         0, 32'h11AB_3344));
    vq.push_back(mk(0, 32'h0000_0020, 0, 1, 4'h0, 32'hFFFF_FFFF, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0020, 1, 0, 4'h0, 32'h0,         0, 32'h11AB_3344));
    vq.push_back(mk(0, 32'h0000_0004, 0, 1, 4'hF, 32'hCAFE_F00D, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_1000, 1, 0, 4'h0, 32'h0,         1, 32'h0));
    vq.push_back(mk(0, 32'h0000_0004, 1, 1, 4'hF, 32'h1234_5678, 1, 32'h0));
    vq.push_back(mk(0, 32'h0000_0004, 1, 0, 4'h0, 32'h0,         0, 32'hCAFE_F00D));
    vq.push_back(mk(0, 32'h0000_1004, 0, 1, 4'hF, 32'h0BAD_0BAD, 1, 32'h0));
    vq.push_back(mk(0, 32'h0000_0004, 1, 0, 4'h0, 32'h0,         0, 32'hCAFE_F00D));
    vq.push_back(mk(0, 32'h0000_0FFC, 0, 1, 4'hF, 32'h1357_9BDF, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0FFC, 1, 0, 4'h0, 32'h0,         0, 32'h1357_9BDF));
    vq.push_back(mk(0, 32'h8000_0000, 1, 0, 4'h0, 32'h0,         1, 32'h0));
    vq.push_back(mk(0, 32'h0000_0008, 0, 1, 4'hF, 32'hA5A5_A5A5, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0008, 0, 1, 4'h3, 32'h0000_1234, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0008, 0, 1, 4'h9, 32'h7700_0088, 0, 32'h0));
    vq.push_back(mk(0, 32'h0000_0008, 1, 0, 4'h0, 32'h0,         0, 32'h77A5_1288));
    vq.push_back(mk(1, 32'h0000_0030, 0, 1, 4'hF, 32'h0102_0304, 0, 32'h0));
    vq.push_back(mk(1, 32'h0000_0030, 1, 0, 4'h0, 32'h0,         0, 32'h0102_0304));
    vq.push_back(mk(1, 32'h0000_2000, 1, 0, 4'h0, 32'h0,         1, 32'h0));
    vq.push_back(mk(2, 32'h0000_0030, 0, 1, 4'hF, 32'h0BAD_F00D, 0, 32'h0));
    vq.push_back(mk(2, 32'h0000_0030, 1, 0, 4'h0, 32'h0,         0, 32'h0BAD_F00D));
    vq.push_back(mk(2, 32'h0000_0030, 1, 1, 4'hF, 32'h0,         1, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_idle($sformatf("reset dut%0d", s));
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vq[i]) do_req(vq[i], i);

    // Held read: accepted, answered, then re-accepted only in the following IDLE cycle.
    sel = 0;
    bus_addr = 32'h0000_0010;
    bus_read = 1'b1;
    pattern = '0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      pattern[n-1] = resp_s;
      if (n == 5) chk("held second rdata", rdata_s, 32'hDEAD_BEEF);
      if (n == 4) bus_read = 1'b0;
    end
    chk("held resp pattern", {22'd0, pattern}, {22'd0, 10'b00_0001_0010});

    // Reset while a write is counting down: no response, no commit.
    bus_addr = 32'h0000_0008;
    bus_write = 1'b1;
    bus_be = 4'hF;
    bus_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_write = 1'b0;
    #1;
    chk_idle("abort in reset");
    @(posedge clk); #1;
    rst = 1'b1;
    pattern = '0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      pattern[n-1] = resp_s;
    end
    chk("abort no resp", {22'd0, pattern}, 32'd0);
    do_req(mk(0, 32'h0000_0008, 1, 0, 4'h0, 32'h0, 0, 32'h77A5_1288), 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipeline's data port. It is the memory-side end of the dmem interface driven by the MEM stage, which drives address, read/write strobes, wdata and byte enables. The block accepts one request at a time, holds it for a parameterised latency, then returns a single-cycle dmem_resp with read data or an error flag. It replaces magic memory in the simulation and FPGA builds, and gives later stall logic a real multi-cycle handshake.

Parameters:
ADDR_WORDS_LOG2, 10, word index width; array depth is 2**ADDR_WORDS_LOG2 32-bit words.
LATENCY, 2, cycles from request accept to dmem_resp; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-low (0 = in reset).
dmem_address  in  32  byte address; bits [1:0] ignored (initiator word-aligns).
dmem_read  in  1  read request; initiator holds it until dmem_resp.
dmem_write  in  1  write request; initiator holds it until dmem_resp.
mem_byte_enable  in  4  write byte lanes; bit i enables wdata[8i+7:8i].
dmem_wdata  in  32  lane-aligned write data.
dmem_rdata  out  32  read word; valid only while dmem_resp=1.
dmem_resp  out  1  one-cycle completion pulse.
dmem_err  out  1  qualifies dmem_resp; the request failed.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, dmem_resp=0, dmem_err=0, dmem_rdata=0. The array is not reset; its contents are retained.
- Reset mid-request: the request is aborted with no response. A write not yet committed is dropped.
- States:
  - IDLE: in a cycle with dmem_read|dmem_write, latch address index, strobes, byte enable and wdata; load counter with LATENCY-1; go to BUSY, or directly to RESP if LATENCY=1.
  - BUSY: decrement the counter each cycle. At 0 go to RESP. Inputs are ignored; only latched copies are used.
  - RESP: dmem_resp=1 for exactly one cycle, then IDLE. Inputs seen in RESP are never accepted, because the initiator is still holding the completed request.
- Latency: request first seen in IDLE at cycle t gives dmem_resp in cycle t+LATENCY. The next request can be accepted at t+LATENCY+1 at the earliest.
- Error conditions (dmem_err=1 with the resp):
  - address bits [31:ADDR_WORDS_LOG2+2] nonzero (out of range);
  - dmem_read and dmem_write both asserted.
  - On error: no array write, dmem_rdata=0.
- Write commit: byte-merge into array[index] on the clock edge entering RESP. A read issued right after the write returns the merged word.
- Write with mem_byte_enable=0000: array unchanged, normal resp, err=0. dmem_rdata=0 for all writes.
- Read: in the RESP cycle, dmem_rdata = array[latched index], the full word. The byte enable is ignored, and byte/half extraction stays in WB.
- Outside RESP: dmem_rdata=0 and dmem_err=0 (registered outputs, no glitch).
- Counter width: 4 bits. Latch registers load only in IDLE on accept.

Decomposition:
- Shared package mem_if_types, holding:
  - the state enum dmem_resp_state_t {IDLE, BUSY, RESP};
  - a dmem_req_t struct (index, read, write, be, wdata) for the latched request;
  - a constant DMEM_MAX_LATENCY=15.
- One sub-module, be_merge: combinational old word, new word and 4-bit enable to merged word. It is reused later by the cache data array.

Test Plan:
- LATENCY=2, write 0xDEADBEEF to 0x00000010 with be=1111 (accepted cycle 5), then read 0x10 → write resp in cycle 7, err=0; read resp 2 cycles after its accept, rdata=0xDEADBEEF.
- Byte merge: preload 0x11223344 at 0x20, write wdata=0x00AB0000 with be=0100, read 0x20 → 0x11AB3344. Then write with be=0000 and read 0x20 → still 0x11AB3344.
- Held request: keep dmem_read=1 through and after the resp cycle for one extra cycle → exactly one dmem_resp pulse per accept, and the next accept happens only in the following IDLE cycle.
- Errors:
  - read of 0x00001000 with ADDR_WORDS_LOG2=10 → resp with err=1, rdata=0;
  - read and write both high at 0x4 → resp with err=1 and memory at 0x4 unchanged.
- LATENCY=1 → resp in the cycle after accept. LATENCY=15 → resp 15 cycles after accept.
- Drop rst to 0 for 1 cycle while a write of 0x55555555 to 0x8 is in BUSY → outputs 0 immediately, no resp. A later read of 0x8 returns the old value.
